inc_counter_bank: RTL and testbench
===================================

Name: inc_counter_bank

Overview:
- Parametrised successor to the processor's one-hot increment decoder.
- Instead of emitting increment strobes to external registers, it owns N_CH internal index counters (ROW, COL, CURR, STA, STB, STC, R1 in the default build).
- Each counter has a programmable wrap limit, a wrap/saturate mode and an optional carry chain, so a COL wrap can advance ROW without controller involvement.
- Sits between the control unit and the address-generation datapath.

Parameters:
- N_CH, 7: number of counters.
- WIDTH, 8: counter and limit width in bits.
- SEL_W, 3: command select width; must satisfy 2^SEL_W >= N_CH.
- SAT_MODE, 0: overflow policy. 0 = wrap to 0; 1 = saturate at the limit.
- CHAIN_MASK, 0 (N_CH bits): if bit i is set, a wrap of channel i increments channel i+1. Bit N_CH-1 is ignored.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe; one command per cycle, no backpressure.
- cmd_op  in  2  operation code: 00 INC, 01 ADD, 10 LOAD, 11 SETLIM.
- cmd_sel  in  SEL_W  binary channel index.
- cmd_data  in  WIDTH  operand for ADD, LOAD and SETLIM.
- ch_val  out  N_CH*WIDTH  counter values; channel i occupies bits [i*WIDTH +: WIDTH]. Registered.
- wrap  out  N_CH  per-channel overflow pulse, one cycle wide, registered.
- chain_out  out  1  one-cycle pulse when a carry leaves channel N_CH-1 (its wrap occurred because of a chain carry).
- sel_err  out  1  one-cycle pulse when cmd_sel >= N_CH.

Behaviour:
- Reset (synchronous, active-high)
  - All counters = 0.
  - All limits = 2^WIDTH-1.
  - wrap, chain_out and sel_err = 0.
  - Reset has priority over any command presented in the same cycle.
- Latency
  - A command accepted at edge k is visible on ch_val/wrap/sel_err after edge k (1 cycle).
  - With cmd_valid=0, all state holds and pulses return to 0.
- INC: delta = 1. ADD: delta = cmd_data (ADD with 0 is a no-op and never wraps).
- Arithmetic
  - sum = val + delta, computed in WIDTH+1 bits.
  - If sum <= lim: val := sum.
  - Otherwise overflow: wrap[i] = 1 and val := 0 (SAT_MODE=0) or val := lim (SAT_MODE=1).
  - In SAT_MODE=1, wrap still pulses on every overflowing command, including while already at the limit.
- Chain
  - Applies only when SAT_MODE=0 and CHAIN_MASK[i]=1.
  - An overflow on channel i applies INC to channel i+1 in the same cycle.
  - The carry ripples combinationally through consecutive chained channels within one clock.
  - Every channel that overflows pulses its own wrap bit.
  - Carry out of channel N_CH-1 pulses chain_out.
  - Only the commanded channel and its chain successors change state in a cycle.
- LOAD: val := min(cmd_data, lim). Never wraps and never chains.
- SETLIM: lim := cmd_data. If the current val > cmd_data, val := 0. No wrap pulse.
- Limit 0: the counter stays at 0; every INC overflows (wrap pulse and chain carry each time).
- Invalid select (cmd_sel >= N_CH): no state change, sel_err = 1 for one cycle. cmd_op is ignored.
- Reset mid-chain or mid-sequence: all counters and limits return to reset values on that edge; no pulses are emitted that cycle.

Test Plan (all scenarios use N_CH=7, WIDTH=8 unless stated):
1. Reset, then INC ch0 three times -> ch0 = 3, all other channels 0, no wrap.
2. SETLIM ch1=4, then INC ch1 five times -> sequence 1,2,3,4,0; wrap[1] pulses exactly on the 5th command only.
3. CHAIN_MASK=7'b0000010, SETLIM ch1=2, INC ch1 six times -> ch1 sequence 1,2,0,1,2,0 and ch2 sequence 0,0,1,1,1,2, with wrap[1] on the 3rd and 6th commands.
4. SAT_MODE=1: SETLIM ch3=10, LOAD ch3=200 -> ch3 = 10 (clamped). Then ADD ch3 by 5 -> ch3 stays 10, wrap[3] pulses.
5. cmd_sel=7 with INC -> sel_err pulses for one cycle, ch_val unchanged. Then LOAD ch6=0xFF followed by INC ch6 -> ch6 = 0, wrap[6] pulses, chain_out stays 0 (CHAIN_MASK=0).
6. Load several channels nonzero, then assert reset together with cmd_valid (INC ch0) -> all counters 0, all limits 0xFF (verify via LOAD ch0=0xFF reading back 0xFF), all pulses 0.

Source files
------------

// File: rtl/inc_counter_bank_if.sv
// Command/status bundle for inc_counter_bank.
//   master : drives cmd_valid/cmd_op/cmd_sel/cmd_data, observes status
//   slave  : the counter bank; drives ch_val, wrap, chain_out, sel_err
//   cmd_op : 00 INC, 01 ADD, 10 LOAD, 11 SETLIM
//   ch_val : channel i at bits [i*WIDTH +: WIDTH]
interface inc_counter_bank_if #(
  parameter int N_CH  = 7,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic [SEL_W-1:0]      cmd_sel;
  logic [WIDTH-1:0]      cmd_data;
  logic [N_CH*WIDTH-1:0] ch_val;
  logic [N_CH-1:0]       wrap;
  logic                  chain_out;
  logic                  sel_err;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_data,
    input  ch_val, wrap, chain_out, sel_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_data,
    output ch_val, wrap, chain_out, sel_err
  );
endinterface

// File: rtl/inc_counter_bank.sv
// inc_counter_bank: N_CH index counters, each with a programmable wrap limit,
// wrap/saturate overflow policy and an optional carry chain into the next
// channel. One command per cycle, results registered (1-cycle latency).
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset (counters 0, limits all-ones)
//   io_bus  : inc_counter_bank_if.slave (command in, values/pulses out)
// SEL_W must satisfy 2**SEL_W >= N_CH.

// One counter channel: value/limit registers plus next-state arithmetic.
module inc_counter_lane #(
  parameter int WIDTH    = 8,
  parameter int SAT_MODE = 0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_hit,      // valid command addressed to this lane
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_carry_in, // chained INC from the lane below
  output logic [WIDTH-1:0] o_val,
  output logic             o_wrap,
  output logic             o_ovf       // combinational overflow this cycle
);
  localparam logic [1:0] OP_INC = 2'd0, OP_ADD = 2'd1, OP_LOAD = 2'd2, OP_SETLIM = 2'd3;

  logic [WIDTH-1:0] r_val, r_lim;
  logic             r_wrap;
  logic             w_arith;
  logic [WIDTH-1:0] w_delta, w_val_nx, w_lim_nx;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  // A carry can only arrive when this lane is not the commanded one (the
  // ripple only moves upward from the commanded lane), so the two never mix.
  always_comb begin
    w_arith  = i_carry_in || (i_hit && (i_op == OP_INC || i_op == OP_ADD));
    w_delta  = (i_hit && i_op == OP_ADD) ? i_data : WIDTH'(1);
    w_sum    = {1'b0, r_val} + {1'b0, w_delta};
    w_ovf    = w_arith && (w_sum > {1'b0, r_lim});
    w_val_nx = r_val;
    w_lim_nx = r_lim;
    if (w_arith) begin
      if (w_ovf) w_val_nx = (SAT_MODE != 0) ? r_lim : '0;
      else       w_val_nx = w_sum[WIDTH-1:0];
    end else if (i_hit && i_op == OP_LOAD) begin
      w_val_nx = (i_data > r_lim) ? r_lim : i_data;
    end else if (i_hit && i_op == OP_SETLIM) begin
      w_lim_nx = i_data;
      // keep val <= lim invariant so ADD 0 can never overflow
      if (r_val > i_data) w_val_nx = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_val  <= '0;
      r_lim  <= '1;
      r_wrap <= 1'b0;
    end else begin
      r_val  <= w_val_nx;
      r_lim  <= w_lim_nx;
      r_wrap <= w_ovf;
    end
  end

  assign o_val  = r_val;
  assign o_wrap = r_wrap;
  assign o_ovf  = w_ovf;
endmodule

module inc_counter_bank #(
  parameter int              N_CH       = 7,
  parameter int              WIDTH      = 8,
  parameter int              SEL_W      = 3,
  parameter int              SAT_MODE   = 0,
  parameter logic [N_CH-1:0] CHAIN_MASK = '0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  inc_counter_bank_if.slave io_bus
);
  logic [N_CH-1:0][WIDTH-1:0] w_val;
  logic [N_CH-1:0]            w_hit, w_wrap, w_ovf, w_carry;
  logic                       w_sel_ok;
  logic                       r_sel_err, r_chain_out;

  assign w_sel_ok = (32'(io_bus.cmd_sel) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign w_hit[i] = io_bus.cmd_valid && w_sel_ok && (io_bus.cmd_sel == SEL_W'(i));

    // Carry into lane i comes from lane i-1; chaining is disabled when saturating.
    if (i == 0) begin : g_c0
      assign w_carry[i] = 1'b0;
    end else begin : g_cn
      assign w_carry[i] = w_ovf[i-1] && (SAT_MODE == 0) && CHAIN_MASK[i-1];
    end

    inc_counter_lane #(.WIDTH(WIDTH), .SAT_MODE(SAT_MODE)) u_lane (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_hit      (w_hit[i]),
      .i_op       (io_bus.cmd_op),
      .i_data     (io_bus.cmd_data),
      .i_carry_in (w_carry[i]),
      .o_val      (w_val[i]),
      .o_wrap     (w_wrap[i]),
      .o_ovf      (w_ovf[i])
    );
  end

  // chain_out flags an overflow of the top lane that was caused by a carry,
  // not a direct command to it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sel_err   <= 1'b0;
      r_chain_out <= 1'b0;
    end else begin
      r_sel_err   <= io_bus.cmd_valid && !w_sel_ok;
      r_chain_out <= w_ovf[N_CH-1] && w_carry[N_CH-1];
    end
  end

  assign io_bus.ch_val    = w_val;
  assign io_bus.wrap      = w_wrap;
  assign io_bus.sel_err   = r_sel_err;
  assign io_bus.chain_out = r_chain_out;
endmodule

// File: tb/tb_inc_counter_bank.sv
module tb_inc_counter_bank;
  localparam logic [1:0] INC = 2'd0, ADD = 2'd1, LOAD = 2'd2, SETLIM = 2'd3;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  inc_counter_bank_if #(.N_CH(7), .WIDTH(8), .SEL_W(3)) b0 ();
  inc_counter_bank_if #(.N_CH(7), .WIDTH(8), .SEL_W(3)) b1 ();
  inc_counter_bank_if #(.N_CH(7), .WIDTH(8), .SEL_W(3)) b2 ();

  // u0: defaults; u1: chained (1->2, 5->6, top bit ignored); u2: saturating
  inc_counter_bank #(.N_CH(7), .WIDTH(8), .SEL_W(3), .SAT_MODE(0), .CHAIN_MASK(7'b0000000))
    u0 (.i_clock(clk), .i_reset(rst), .io_bus(b0));
  inc_counter_bank #(.N_CH(7), .WIDTH(8), .SEL_W(3), .SAT_MODE(0), .CHAIN_MASK(7'b1100010))
    u1 (.i_clock(clk), .i_reset(rst), .io_bus(b1));
  inc_counter_bank #(.N_CH(7), .WIDTH(8), .SEL_W(3), .SAT_MODE(1), .CHAIN_MASK(7'b1111111))
    u2 (.i_clock(clk), .i_reset(rst), .io_bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    b0.cmd_valid = 1'b0; b1.cmd_valid = 1'b0; b2.cmd_valid = 1'b0;
  endtask

  task automatic drive(input int d, input logic [1:0] op, input logic [2:0] sel, input logic [7:0] data);
    case (d)
      0: begin b0.cmd_valid = 1'b1; b0.cmd_op = op; b0.cmd_sel = sel; b0.cmd_data = data; end
      1: begin b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_sel = sel; b1.cmd_data = data; end
      default: begin b2.cmd_valid = 1'b1; b2.cmd_op = op; b2.cmd_sel = sel; b2.cmd_data = data; end
    endcase
  endtask

  // Present one command for one edge, then sample 1 time unit after it.
  task automatic cmd(input int d, input logic [1:0] op, input logic [2:0] sel, input logic [7:0] data);
    @(negedge clk); idle_all(); drive(d, op, sel, data);
    @(posedge clk); #1; idle_all();
  endtask

  task automatic tick();
    @(negedge clk); idle_all();
    @(posedge clk); #1;
  endtask

  function automatic logic [55:0] vals(input int d);
    case (d)
      0: return b0.ch_val;
      1: return b1.ch_val;
      default: return b2.ch_val;
    endcase
  endfunction

  function automatic logic [7:0] ch(input int d, input int i);
    logic [55:0] v;
    v = vals(d);
    return v[i*8 +: 8];
  endfunction

  function automatic logic [6:0] wrp(input int d);
    case (d)
      0: return b0.wrap;
      1: return b1.wrap;
      default: return b2.wrap;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin : stim
    logic [7:0] e1 [6];
    logic [7:0] e2 [6];
    e1 = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
    e2 = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};

    rst = 1'b1;
    idle_all();
    b0.cmd_op = '0; b0.cmd_sel = '0; b0.cmd_data = '0;
    b1.cmd_op = '0; b1.cmd_sel = '0; b1.cmd_data = '0;
    b2.cmd_op = '0; b2.cmd_sel = '0; b2.cmd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val",   vals(0), 64'h0);
    chk("rst_wrap",  wrp(0), 64'h0);
    chk("rst_serr",  b0.sel_err, 64'h0);
    chk("rst_chain", b1.chain_out, 64'h0);
    @(negedge clk); rst = 1'b0;

    // 1: INC ch0 three times
    for (int k = 0; k < 3; k++) begin
      cmd(0, INC, 3'd0, 8'd0);
      chk("s1_ch0", ch(0, 0), 64'(k + 1));
      chk("s1_wrap", wrp(0), 64'h0);
    end
    chk("s1_all", vals(0), 64'h3);

    // 2: limit 4 on ch1, wrap on the 5th INC only
    cmd(0, SETLIM, 3'd1, 8'd4);
    chk("s2_setlim_wrap", wrp(0), 64'h0);
    for (int k = 0; k < 5; k++) begin
      cmd(0, INC, 3'd1, 8'd0);
      chk("s2_ch1",  ch(0, 1), (k == 4) ? 64'd0 : 64'(k + 1));
      chk("s2_wrap", wrp(0),   (k == 4) ? 64'h02 : 64'h0);
    end
    tick();
    chk("s2_wrap_clr", wrp(0), 64'h0);

    // 5: invalid select, then plain overflow on ch6 without chain
    cmd(0, INC, 3'd7, 8'd0);
    chk("s5_serr", b0.sel_err, 64'h1);
    chk("s5_hold", vals(0), 64'h3);
    tick();
    chk("s5_serr_clr", b0.sel_err, 64'h0);
    cmd(0, LOAD, 3'd6, 8'hFF);
    chk("s5_ld6", ch(0, 6), 64'hFF);
    cmd(0, INC, 3'd6, 8'd0);
    chk("s5_ch6", ch(0, 6), 64'h0);
    chk("s5_wrap", wrp(0), 64'h40);
    chk("s5_chain", b0.chain_out, 64'h0);

    // limit 0, ADD boundaries, SETLIM below current value, LOAD clamp
    cmd(0, SETLIM, 3'd2, 8'd0);
    cmd(0, INC, 3'd2, 8'd0);
    chk("lim0_ch2", ch(0, 2), 64'h0);
    chk("lim0_wrap", wrp(0), 64'h04);
    cmd(0, ADD, 3'd0, 8'd0);
    chk("add0_ch0", ch(0, 0), 64'd3);
    chk("add0_wrap", wrp(0), 64'h0);
    cmd(0, ADD, 3'd0, 8'd250);
    chk("add250", ch(0, 0), 64'd253);
    cmd(0, ADD, 3'd0, 8'd3);
    chk("add_ovf_ch0", ch(0, 0), 64'd0);
    chk("add_ovf_wrap", wrp(0), 64'h01);
    cmd(0, LOAD, 3'd4, 8'd50);
    cmd(0, SETLIM, 3'd4, 8'd20);
    chk("setlim_clr", ch(0, 4), 64'd0);
    chk("setlim_nowrap", wrp(0), 64'h0);
    cmd(0, LOAD, 3'd4, 8'd30);
    chk("load_clamp", ch(0, 4), 64'd20);

    // 3: chain ch1 -> ch2
    cmd(1, SETLIM, 3'd1, 8'd2);
    for (int k = 0; k < 6; k++) begin
      cmd(1, INC, 3'd1, 8'd0);
      chk("s3_ch1",  ch(1, 1), 64'(e1[k]));
      chk("s3_ch2",  ch(1, 2), 64'(e2[k]));
      chk("s3_wrap", wrp(1), (k == 2 || k == 5) ? 64'h02 : 64'h0);
    end

    // ripple ch5 -> ch6 -> chain_out with both limits at 0
    cmd(1, SETLIM, 3'd5, 8'd0);
    cmd(1, SETLIM, 3'd6, 8'd0);
    cmd(1, INC, 3'd5, 8'd0);
    chk("rip_wrap", wrp(1), 64'h60);
    chk("rip_chain", b1.chain_out, 64'h1);
    chk("rip_ch6", ch(1, 6), 64'h0);
    cmd(1, INC, 3'd6, 8'd0);
    chk("top_wrap", wrp(1), 64'h40);
    chk("top_nochain", b1.chain_out, 64'h0);

    // 4: saturating bank; chain mask has no effect
    cmd(2, SETLIM, 3'd3, 8'd10);
    cmd(2, LOAD, 3'd3, 8'd200);
    chk("s4_clamp", ch(2, 3), 64'd10);
    cmd(2, ADD, 3'd3, 8'd5);
    chk("s4_sat", ch(2, 3), 64'd10);
    chk("s4_wrap", wrp(2), 64'h08);
    cmd(2, INC, 3'd3, 8'd0);
    chk("s4_sat_again", wrp(2), 64'h08);
    chk("s4_all", vals(2), 64'h0A000000);

    // 6: reset together with commands (dut1 would otherwise ripple)
    cmd(0, LOAD, 3'd3, 8'd9);
    @(negedge clk); idle_all();
    rst = 1'b1;
    drive(0, INC, 3'd0, 8'd0);
    drive(1, INC, 3'd5, 8'd0);
    @(posedge clk); #1;
    chk("s6_val0", vals(0), 64'h0);
    chk("s6_val1", vals(1), 64'h0);
    chk("s6_wrap0", wrp(0), 64'h0);
    chk("s6_wrap1", wrp(1), 64'h0);
    chk("s6_chain", b1.chain_out, 64'h0);
    @(negedge clk); idle_all(); rst = 1'b0;
    cmd(0, LOAD, 3'd0, 8'hFF);
    chk("s6_lim0", ch(0, 0), 64'hFF);
    cmd(0, LOAD, 3'd2, 8'hFF);
    chk("s6_lim2", ch(0, 2), 64'hFF);
    cmd(1, LOAD, 3'd6, 8'hFF);
    chk("s6_lim6", ch(1, 6), 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
